fft_input_framer: RTL

//  Upstream stage of the 32-point DIT FFT top. Collects a serial stream of real N-bit
//  Q-format samples into 32-sample frames and presents each complete frame in parallel
//  (slot k drives ink_r of the FFT). Ping-pong buffered, so filling continues while the
//  FFT holds a frame. Samples pass through unmodified; no arithmetic or scaling.

---
 rtl/fft_input_framer_if.sv | 24 ++
 rtl/fft_input_framer.sv | 87 ++++++++
 2 files changed

// File: rtl/fft_input_framer_if.sv
// Sample-stream and frame-presentation signals between the framer, its source and the FFT.
interface fft_input_framer_if #(
  parameter int N   = 16,
  parameter int PTS = 32
);
  logic               s_valid;
  logic               s_sof;
  logic [N-1:0]       s_data;
  logic               s_ready;
  logic               frame_valid;
  logic [PTS*N-1:0]   frame_data;
  logic               frame_ack;
  logic               sync_err;

  modport master (
    output s_valid, s_sof, s_data, frame_ack,
    input  s_ready, frame_valid, frame_data, sync_err
  );

  modport slave (
    input  s_valid, s_sof, s_data, frame_ack,
    output s_ready, frame_valid, frame_data, sync_err
  );
endinterface

// File: rtl/fft_input_framer.sv
// Ping-pong framer: packs a serial sample stream into 32-sample frames presented in
// parallel to the FFT while the other bank keeps filling.
module fft_input_framer #(
  parameter int N   = 16,
  parameter int PTS = 32
) (
  input  logic              clk2,
  input  logic              rst,
  fft_input_framer_if.slave bus
);
  localparam int IDX_W = $clog2(PTS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PTS - 1);

  // Fill state counts how many banks hold a complete, unconsumed frame.
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  logic [1:0]       state, state_n;
  logic             wr_bank, rd_bank;
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] wr_addr;
  logic [N-1:0]     bank [2][PTS];
  logic             s_ready_q, frame_valid_q, sync_err_q;
  logic             accept, complete, discard, ack;
  logic [PTS*N-1:0] frame_flat;

  assign accept   = bus.s_valid & s_ready_q;
  // A start-of-frame sample restarts the fill, so it can never complete a frame.
  assign complete = accept & ~bus.s_sof & (wr_idx == LAST_IDX);
  assign discard  = accept & bus.s_sof & (wr_idx != '0);
  assign ack      = bus.frame_ack & frame_valid_q;
  assign wr_addr  = bus.s_sof ? '0 : wr_idx;

  // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    state_n = state;
    unique case ({complete, ack})
      2'b10:   state_n = (state == ST_EMPTY) ? ST_ONE : ST_TWO;
      2'b01:   state_n = (state == ST_TWO)   ? ST_ONE : ST_EMPTY;
      default: state_n = state;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk2 or negedge rst) begin
    if (!rst) begin
      state         <= ST_EMPTY;
      wr_bank       <= 1'b0;
      rd_bank       <= 1'b0;
      wr_idx        <= '0;
      s_ready_q     <= 1'b1;
      frame_valid_q <= 1'b0;
      sync_err_q    <= 1'b0;
    end else begin
      state         <= state_n;
      s_ready_q     <= (state_n != ST_TWO);
      frame_valid_q <= (state_n != ST_EMPTY);
      sync_err_q    <= discard;
      if (accept) wr_idx <= bus.s_sof ? IDX_W'(1) : wr_idx + IDX_W'(1);
      if (complete) wr_bank <= ~wr_bank;
      if (ack) rd_bank <= ~rd_bank;
    end
  end

  // NOTE: the banks are reset on purpose: frame_data must read as zero straight out of reset.
  always_ff @(posedge clk2 or negedge rst) begin
    if (!rst) begin
      for (int b = 0; b < 2; b++)
        for (int k = 0; k < PTS; k++)
          bank[b][k] <= '0;
    end else if (accept) begin
      bank[wr_bank][wr_addr] <= bus.s_data;
    end
  end

  always_comb begin
    frame_flat = '0;
    for (int k = 0; k < PTS; k++)
      frame_flat[k*N +: N] = bank[rd_bank][k];
  end

  assign bus.frame_data  = frame_flat;
  assign bus.s_ready     = s_ready_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.sync_err    = sync_err_q;
endmodule
